lc3_ctrl_fsm: RTL

LC3_CTRL_FSM -- requirements
Module: lc3_ctrl_fsm

---
 rtl/lc3_pkg.sv | 33 +++
 rtl/lc3_ctrl_fsm_if.sv | 29 ++
 rtl/lc3_mem_wait.sv | 24 ++
 rtl/lc3_ctrl_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 control sequencer: state encoding, opcodes and
// the mux-select encodings driven onto the datapath.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_F18, S_F33, S_F35, S_PAUSE1, S_PAUSE2, S_D32,
    S_ADD1, S_AND5, S_NOT9, S_BR0, S_BR22, S_JMP12,
    S_JSR4, S_JSR21, S_JSRR20, S_LDR6, S_LDR25, S_LDR27,
    S_STR7, S_STR23, S_STR16, S_PSE13A, S_PSE13B
  } state_t;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_JSR = 4'b0100,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_JMP = 4'b1100,
    OP_PSE = 4'b1101
  } opcode_t;

  typedef enum logic [1:0] {ALUK_ADD, ALUK_AND, ALUK_NOT, ALUK_PASSA} aluk_t;
  typedef enum logic [1:0] {PCMUX_PC1, PCMUX_BUS, PCMUX_ADDER} pcmux_t;
  typedef enum logic [1:0] {ADDR2_ZERO, ADDR2_OFF6, ADDR2_OFF9, ADDR2_OFF11} addr2mux_t;

  // States that hold the SRAM strobes for a counted number of cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_F33) || (s == S_LDR25) || (s == S_STR16);
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// Front-panel, instruction-field inputs and datapath/SRAM control outputs
// of the LC-3 sequencer; master is the controller side.
interface lc3_ctrl_fsm_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN,
           PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN,
           PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_mem_wait.sv
// SRAM dwell counter: loaded with MEM_WAIT-1 on entry to a memory state,
// counts down while the access is held, done when it reaches zero.
module lc3_mem_wait #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);
  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 4'd0;
    else if (load)
      count <= 4'(MEM_WAIT - 1);
    else if (dec && (count != 4'd0))
      count <= count - 4'd1;
  end

  assign done = (count == 4'd0);
endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control sequencer: fetch, decode and execute of the
// supported opcode subset, with counted SRAM accesses and front-panel pauses.
module lc3_ctrl_fsm import lc3_pkg::*; #(
  parameter int MEM_WAIT    = 2,
  parameter bit PAUSE_IR_EN = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  lc3_ctrl_fsm_if.master bus
);
  state_t state, next_state;
  logic   led_shown;
  logic   cnt_load, cnt_dec, cnt_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_HALTED;
      led_shown <= 1'b0;
    end else begin
      state     <= next_state;
      led_shown <= (state == S_PSE13A);
    end
  end

  // Reload only on entry; a memory state that stays put just counts down.
  assign cnt_load = is_mem_state(next_state) && (next_state != state);
  assign cnt_dec  = is_mem_state(state) && !cnt_done;

  lc3_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk  (Clk),
    .rst  (Reset),
    .load (cnt_load),
    .dec  (cnt_dec),
    .done (cnt_done)
  );

  assign bus.Mem_CE = 1'b0;
  assign bus.Mem_UB = 1'b0;
  assign bus.Mem_LB = 1'b0;

  always_comb begin
    next_state     = state;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.PCMUX      = PCMUX_PC1;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;

    case (state)
      S_HALTED: if (bus.Run) next_state = S_F18;
      S_F18: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        next_state = S_F33;
      end
      S_F33, S_LDR25: begin
        bus.Mem_OE = 1'b0;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = 1'b1;
        if (cnt_done) next_state = (state == S_F33) ? S_F35 : S_LDR27;
      end
      S_F35: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        next_state  = PAUSE_IR_EN ? S_PAUSE1 : S_D32;
      end
      S_PAUSE1: if (bus.Continue)  next_state = S_PAUSE2;
      S_PAUSE2: if (!bus.Continue) next_state = S_D32;
      S_D32: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          OP_ADD:  next_state = S_ADD1;
          OP_AND:  next_state = S_AND5;
          OP_NOT:  next_state = S_NOT9;
          OP_BR:   next_state = S_BR0;
          OP_JMP:  next_state = S_JMP12;
          OP_JSR:  next_state = S_JSR4;
          OP_LDR:  next_state = S_LDR6;
          OP_STR:  next_state = S_STR7;
          OP_PSE:  next_state = S_PSE13A;
          default: next_state = S_F18;
        endcase
      end
      S_ADD1, S_AND5, S_NOT9: begin
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = (state == S_NOT9) ? 1'b1 : bus.IR_5;
        bus.ALUK    = (state == S_ADD1) ? ALUK_ADD :
                      (state == S_AND5) ? ALUK_AND : ALUK_NOT;
        next_state  = S_F18;
      end
      S_BR0: next_state = bus.BEN ? S_BR22 : S_F18;
      S_BR22: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PCMUX_ADDER;
        bus.ADDR2MUX = ADDR2_OFF9;
        next_state   = S_F18;
      end
      S_JMP12, S_JSRR20: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PCMUX_ADDER;
        bus.ADDR1MUX = 1'b1;
        bus.SR1MUX   = 1'b1;
        next_state   = S_F18;
      end
      S_JSR4: begin
        bus.GatePC = 1'b1;
        bus.LD_REG = 1'b1;
        bus.DRMUX  = 1'b1;
        next_state = bus.IR_11 ? S_JSR21 : S_JSRR20;
      end
      S_JSR21: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PCMUX_ADDER;
        bus.ADDR2MUX = ADDR2_OFF11;
        next_state   = S_F18;
      end
      S_LDR6, S_STR7: begin
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.SR1MUX     = 1'b1;
        bus.ADDR2MUX   = ADDR2_OFF6;
        next_state     = (state == S_LDR6) ? S_LDR25 : S_STR23;
      end
      S_LDR27: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        next_state  = S_F18;
      end
      S_STR23: begin
        bus.GateALU = 1'b1;
        bus.ALUK    = ALUK_PASSA;
        bus.LD_MDR  = 1'b1;
        next_state  = S_STR16;
      end
      S_STR16: begin
        bus.Mem_WE = 1'b0;
        if (cnt_done) next_state = S_F18;
      end
      // LED latches once on entry even though the state may wait many cycles.
      S_PSE13A: begin
        bus.LD_LED = !led_shown;
        if (bus.Continue) next_state = S_PSE13B;
      end
      S_PSE13B: if (!bus.Continue) next_state = S_F18;
      default: next_state = S_HALTED;
    endcase
  end
endmodule
